// File: rtl/rv32i_types_pkg.sv
// Shared RV32I writeback types.
//   word_t   : 32-bit architectural data word
//   wb_req_t : one register-file write request (destination + data)
//   REG_COUNT: number of architectural integer registers
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    localparam int REG_COUNT = 32;

    typedef struct packed {
        logic [4:0] rd;
        word_t      data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests.
// Ports:
//   CLK, RST   : clock (rising edge), synchronous active-high reset (flushes)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : request to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : entry at the head, valid when count != 0
//   count      : number of buffered entries, 0..DEPTH
module wb_fifo
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    wb_req_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        w_do_push = push && (r_count != FULL_COUNT);
        w_do_pop  = pop  && (r_count != {CW{1'b0}});
    end

    // Storage array; not reset, contents are only meaningful below count.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Register-file write-port arbiter for RV32I.
// Merges single-cycle pipeline writebacks with buffered long-latency (LU)
// results and tracks outstanding LU destinations in a pending scoreboard.
// Ports:
//   CLK, RST                      : clock, synchronous active-high reset
//   pipe_wen/pipe_rd/pipe_wdata   : pipeline writeback (highest priority)
//   lu_valid/lu_ready/lu_rd/lu_wdata : LU result handshake into the FIFO
//   issue_lu/issue_rd             : LU op issue, marks destination pending
//   pending                       : scoreboard bitmap, bit 0 always 0
//   w_data/rd/wen                 : registered register-file write
module rv32i_wb_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 pipe_wen,
    input  logic [4:0]           pipe_rd,
    input  word_t                pipe_wdata,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [4:0]           lu_rd,
    input  word_t                lu_wdata,
    input  logic                 issue_lu,
    input  logic [4:0]           issue_rd,
    output logic [REG_COUNT-1:0] pending,
    output word_t                w_data,
    output logic [4:0]           rd,
    output logic                 wen
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]        FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [REG_COUNT-1:0] ONE_HOT0   = {{(REG_COUNT-1){1'b0}}, 1'b1};

    logic [CW-1:0]        w_count;
    wb_req_t              w_head;
    wb_req_t              w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pipe_sel;
    logic [REG_COUNT-1:0] w_set_mask;
    logic [REG_COUNT-1:0] w_clr_mask;
    logic [REG_COUNT-1:0] w_pending_next;

    logic                 r_wen;
    logic [4:0]           r_rd;
    word_t                r_wdata;
    logic [REG_COUNT-1:0] r_pending;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_push_req),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    // Ready comes from the registered count only: no pop-through when full.
    assign lu_ready = (w_count < FULL_COUNT);

    // Accept/drop, arbitration and scoreboard masks.
    always_comb begin
        w_push_req.rd   = lu_rd;
        w_push_req.data = lu_wdata;
        // Writes to x0 are accepted but discarded.
        w_push     = lu_valid && lu_ready && (lu_rd != 5'd0);
        w_pipe_sel = pipe_wen && (pipe_rd != 5'd0);
        w_pop      = !w_pipe_sel && (w_count != {CW{1'b0}});

        if (w_pop) begin
            w_clr_mask = ONE_HOT0 << w_head.rd;
        end else begin
            w_clr_mask = {REG_COUNT{1'b0}};
        end

        if (issue_lu && (issue_rd != 5'd0)) begin
            w_set_mask = ONE_HOT0 << issue_rd;
        end else begin
            w_set_mask = {REG_COUNT{1'b0}};
        end

        // Set is applied after clear so a same-index collision stays pending.
        w_pending_next    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_next[0] = 1'b0;
    end

    // Registered write port; rd/data hold when nothing is selected.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wen   <= 1'b0;
            r_rd    <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_pipe_sel) begin
            r_wen   <= 1'b1;
            r_rd    <= pipe_rd;
            r_wdata <= pipe_wdata;
        end else if (w_pop) begin
            r_wen   <= 1'b1;
            r_rd    <= w_head.rd;
            r_wdata <= w_head.data;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    // Pending scoreboard.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= {REG_COUNT{1'b0}};
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign wen     = r_wen;
    assign rd      = r_rd;
    assign w_data  = r_wdata;
    assign pending = r_pending;

endmodule
